// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage access controller.
package mem_pkg;

    // Access FSM: idle/issue, waiting for the memory, one-cycle result slot.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Load data presented when the watchdog abandons an access.
    localparam logic [31:0] MEM_ERR_DATA = 32'hDEAD_BEEF;

    // Default data-memory word-address width.
    localparam int unsigned ADDR_W_DEFAULT = 16;

endpackage

// File: rtl/mem_watchdog.sv
// Wait-cycle watchdog: counts enabled cycles and flags the cycle in which
// the LIMIT-th consecutive enabled cycle occurs.
module mem_watchdog #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    // Count enabled cycles; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: issues a request/ready access to the data
// memory, stalls upstream while it is outstanding and zeroes the writeback
// controls (bubbles) until the access completes.
// Optional feature: define MEM_TIMEOUT_EN to enable the WAIT watchdog and
// the MemErr timeout pulse.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCSrcM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic [2:0]        WA3M,
    output logic              PCSrcMo,
    output logic              RegWriteMo,
    output logic              MemtoRegMo,
    output logic [31:0]       ALUResultMo,
    output logic [31:0]       MemOut,
    output logic [2:0]        WA3Mo,
    output logic              StallM,
    output logic              MemReq,
    output logic              MemWE,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWData,
    input  logic              MemReady,
    input  logic [31:0]       MemRData,
    output logic              MemErr
);

    mem_state_t  state_q, state_d;
    logic [31:0] data_q;
    logic        err_q;
    logic        memop;
    logic        req_c, stall_c, pass_c, capture_c, to_err_c;
    logic [31:0] mem_out_c;
    logic        wd_expired;

    assign memop = MemtoRegM | MemWriteM;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured load data and the timeout flag for the following DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= to_err_c;
            if (capture_c && MemtoRegM) begin
                data_q <= MemRData;
            end else if (to_err_c) begin
                data_q <= MEM_ERR_DATA;
            end
        end
    end

    // Next-state logic and request/stall/bubble decode.
    always_comb begin
        state_d   = state_q;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        pass_c    = 1'b1;
        capture_c = 1'b0;
        to_err_c  = 1'b0;
        mem_out_c = data_q;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    pass_c  = 1'b0;
                    if (MemReady) begin
                        state_d   = DONE;
                        capture_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                pass_c  = 1'b0;
                if (MemReady) begin
                    state_d   = DONE;
                    capture_c = 1'b1;
                end else if (wd_expired) begin
                    state_d  = DONE;
                    to_err_c = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (MemWriteM && !err_q) begin
                    mem_out_c = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset forces a bubble and withdraws any outstanding request.
    assign MemReq     = req_c & ~rst;
    assign StallM     = stall_c & ~rst;
    assign PCSrcMo    = PCSrcM & pass_c & ~rst;
    assign RegWriteMo = RegWriteM & pass_c & ~err_q & ~rst;
    assign MemtoRegMo = MemtoRegM & pass_c & ~rst;
    assign MemOut     = mem_out_c;

    assign ALUResultMo = ALUResultM;
    assign WA3Mo       = WA3M;
    assign MemAddr     = ALUResultM[ADDR_W+1:2];
    assign MemWData    = WriteDataM;
    assign MemWE       = MemReq & MemWriteM;

`ifdef MEM_TIMEOUT_EN
    logic wd_clr, wd_en;
    assign wd_clr = (state_q == DONE);
    assign wd_en  = (state_q == WAIT);

    mem_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );

    assign MemErr = err_q & ~rst;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign wd_expired     = 1'b0;
    assign MemErr         = 1'b0;
`endif

endmodule
